// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator command path: command codes,
// command-word field positions and the byte assembler state encodings.
package pulse_pkg;

  // Command codes carried in the top byte of every command word.
  localparam logic [7:0] CMD_RESET_CLOCK      = 8'd0;
  localparam logic [7:0] CMD_SEND_PULSE       = 8'd1;
  localparam logic [7:0] CMD_SET_PERIOD       = 8'd2;
  localparam logic [7:0] CMD_SET_PHASE_MEAS   = 8'd3;
  localparam logic [7:0] CMD_RESET_PHASE_MEAS = 8'd4;
  localparam logic [7:0] CMD_MAX              = 8'd4;

  // Big-endian command word layout: command | coarse | fine.
  localparam int unsigned CMD_MSB    = 31;
  localparam int unsigned CMD_LSB    = 24;
  localparam int unsigned COARSE_MSB = 23;
  localparam int unsigned COARSE_LSB = 8;
  localparam int unsigned FINE_MSB   = 7;
  localparam int unsigned FINE_LSB   = 0;

  // Assembler states; the 8-bit width is exposed directly on state_out.
  typedef enum logic [7:0] {
    S_COLLECT = 8'h00,
    S_PUSH    = 8'h01
  } asm_state_e;

  // Extract the command code from an assembled word.
  function automatic logic [7:0] cmd_field(input logic [31:0] word);
    return word[CMD_MSB:CMD_LSB];
  endfunction

endpackage

// File: rtl/pulse_cmd_assembler_sat_counter.sv
// sat_counter: saturating up-counter with increment enable and synchronous
// clear, used for the assembler's software-visible status counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear wins, otherwise step up until all ones and stick there.
  always_comb begin
    // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pulse_cmd_assembler.sv
// pulse_cmd_assembler: packs host bytes (valid/ready) into big-endian 32-bit
// command words and writes them into the pulse generator command FIFO.
// Partial words idle for TIMEOUT_CYCLES clocks are discarded and counted.
// Build option: define CMD_FILTER_EN to drop words whose command code is
// above CMD_MAX instead of writing them (counted in reject_count).
module pulse_cmd_assembler
  import pulse_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_byte_data,
  input  logic             s_byte_valid,
  output logic             s_byte_ready,
  input  logic             fifo_full,
  output logic [31:0]      fifo_data,
  output logic             fifo_write,
  output logic [31:0]      word_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [CNT_W-1:0] reject_count,
  output logic [7:0]       state_out
);

  // The idle timer only ever needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned      TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  asm_state_e       state_q;
  logic [1:0]       byte_idx_q;
  logic [31:0]      word_q;
  logic [TMR_W-1:0] timer_q;
  logic [31:0]      fifo_data_q;
  logic             fifo_write_q;
  logic [31:0]      word_count_q;

  logic handshake;
  logic expire;
  logic reject;
  logic illegal;

  // Per-cycle events shared by the FSM and the status counters.
  always_comb begin
    handshake = s_byte_valid && (state_q == S_COLLECT);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    expire    = (state_q == S_COLLECT) && (byte_idx_q != 2'd0) && !handshake
                && (timer_q == TMR_LAST);
    illegal   = (state_q != S_COLLECT) && (state_q != S_PUSH);
`ifdef CMD_FILTER_EN
    // Unknown command codes are dropped whether or not the FIFO has room.
    reject    = (state_q == S_PUSH) && (cmd_field(word_q) > CMD_MAX);
`else
    reject    = 1'b0;
`endif
  end

  // Assembler FSM with registered FIFO write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_COLLECT;
      byte_idx_q   <= 2'd0;
      word_q       <= '0;
      timer_q      <= '0;
      fifo_data_q  <= '0;
      fifo_write_q <= 1'b0;
      word_count_q <= '0;
    end else begin
      // Write strobe is a one-cycle pulse unless re-asserted below.
      fifo_write_q <= 1'b0;
      case (state_q)
        S_COLLECT: begin
          if (handshake) begin
            word_q  <= {word_q[23:0], s_byte_data};
            timer_q <= '0;
            if (byte_idx_q == 2'd3) begin
              byte_idx_q <= 2'd0;
              state_q    <= S_PUSH;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end else if (byte_idx_q == 2'd0) begin
            timer_q <= '0;
          end else if (expire) begin
            // Partial bytes are simply forgotten; the next word shifts in fresh.
            byte_idx_q <= 2'd0;
            timer_q    <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_PUSH: begin
          if (reject) begin
            state_q <= S_COLLECT;
          end else if (!fifo_full) begin
            fifo_data_q  <= word_q;
            fifo_write_q <= 1'b1;
            word_count_q <= word_count_q + 32'd1;
            state_q      <= S_COLLECT;
          end
        end
        default: begin
          state_q      <= S_COLLECT;
          byte_idx_q   <= 2'd0;
          word_q       <= '0;
          timer_q      <= '0;
          fifo_data_q  <= '0;
          word_count_q <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (illegal),
    .inc_i   (expire),
    .count_o (timeout_count)
  );

`ifdef CMD_FILTER_EN
  sat_counter #(.W(CNT_W)) u_reject_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (illegal),
    .inc_i   (reject),
    .count_o (reject_count)
  );
`else
  assign reject_count = '0;
`endif

  assign s_byte_ready = (state_q == S_COLLECT);
  assign fifo_data    = fifo_data_q;
  assign fifo_write   = fifo_write_q;
  assign word_count   = word_count_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_pulse_cmd_assembler.sv
// Self-checking bench for pulse_cmd_assembler: directed scenarios plus
// randomized traffic, compared every cycle against a byte-queue model.
module tb_pulse_cmd_assembler;

  localparam int unsigned T_CYC = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic             clk;
  logic             rst;
  logic [7:0]       s_byte_data;
  logic             s_byte_valid;
  logic             s_byte_ready;
  logic             fifo_full;
  logic [31:0]      fifo_data;
  logic             fifo_write;
  logic [31:0]      word_count;
  logic [CNT_W-1:0] timeout_count;
  logic [CNT_W-1:0] reject_count;
  logic [7:0]       state_out;

  pulse_cmd_assembler #(.TIMEOUT_CYCLES(T_CYC), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_byte_data   (s_byte_data),
    .s_byte_valid  (s_byte_valid),
    .s_byte_ready  (s_byte_ready),
    .fifo_full     (fifo_full),
    .fifo_data     (fifo_data),
    .fifo_write    (fifo_write),
    .word_count    (word_count),
    .timeout_count (timeout_count),
    .reject_count  (reject_count),
    .state_out     (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes of the word being collected, a pending word
  // waiting for the FIFO, idle-cycle count and the expected counters.
  logic [7:0]       m_part[$];
  bit               m_busy;
  logic [31:0]      m_word;
  int               m_idle;
  bit               m_exp_wr;
  logic [31:0]      m_exp_data;
  logic [31:0]      m_words;
  logic [CNT_W-1:0] m_tos;
  logic [CNT_W-1:0] m_rejs;

  // Write monitor.
  int          wr_seen;
  logic [31:0] last_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_part.delete();
    m_busy     = 1'b0;
    m_word     = '0;
    m_idle     = 0;
    m_exp_wr   = 1'b0;
    m_exp_data = '0;
    m_words    = '0;
    m_tos      = '0;
    m_rejs     = '0;
  endtask

  // Advance the model by one clock edge using the inputs applied for it.
  task automatic model_edge(input bit v, input logic [7:0] d, input bit f);
    m_exp_wr = 1'b0;
    if (m_busy) begin
`ifdef CMD_FILTER_EN
      if (m_word[31:24] > 8'd4) begin
        m_busy = 1'b0;
        if (m_rejs != CNT_SAT) m_rejs++;
      end else
`endif
      if (!f) begin
        m_exp_wr   = 1'b1;
        m_exp_data = m_word;
        m_words    = m_words + 32'd1;
        m_busy     = 1'b0;
      end
    end else if (v) begin
      m_part.push_back(d);
      m_idle = 0;
      if (m_part.size() == 4) begin
        m_word = {m_part[0], m_part[1], m_part[2], m_part[3]};
        m_part.delete();
        m_busy = 1'b1;
      end
    end else if (m_part.size() > 0) begin
      m_idle++;
      if (m_idle == int'(T_CYC)) begin
        m_part.delete();
        m_idle = 0;
        if (m_tos != CNT_SAT) m_tos++;
      end
    end
  endtask

  // One clock cycle: check ready, drive, clock, update model, check outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit f);
    check("ready", 64'(s_byte_ready), 64'(!m_busy));
    s_byte_valid = v;
    s_byte_data  = d;
    fifo_full    = f;
    @(posedge clk);
    model_edge(v, d, f);
    #1;
    check("fifo_write", 64'(fifo_write), 64'(m_exp_wr));
    check("fifo_data", 64'(fifo_data), 64'(m_exp_data));
    check("word_count", 64'(word_count), 64'(m_words));
    check("timeout_count", 64'(timeout_count), 64'(m_tos));
    check("reject_count", 64'(reject_count), 64'(m_rejs));
    check("state_out", 64'(state_out), 64'(m_busy ? 8'd1 : 8'd0));
    if (fifo_write === 1'b1) begin
      wr_seen++;
      last_data = fifo_data;
    end
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n, input bit f);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, f);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    rst          = 1'b0;
    s_byte_valid = 1'b0;
    fifo_full    = 1'b0;
    #2;
    check("rst_ready", 64'(s_byte_ready), 64'd1);
    check("rst_fifo_write", 64'(fifo_write), 64'd0);
    check("rst_fifo_data", 64'(fifo_data), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_timeout_count", 64'(timeout_count), 64'd0);
    check("rst_reject_count", 64'(reject_count), 64'd0);
    check("rst_state_out", 64'(state_out), 64'd0);
    #2;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int r0;
    int vprob;
    int fprob;
    rst          = 1'b0;
    s_byte_valid = 1'b0;
    s_byte_data  = 8'h00;
    fifo_full    = 1'b0;
    wr_seen      = 0;
    last_data    = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back word, FIFO ready.
    w0 = wr_seen;
    send(8'h01); send(8'h00); send(8'h05); send(8'h03);
    idle(3, 1'b0);
    check("tp1_writes", 64'(wr_seen - w0), 64'd1);
    check("tp1_data", 64'(last_data), 64'h01000503);
    check("tp1_word_count", 64'(word_count), 64'd1);

    // FIFO full for 20 cycles after the 4th byte.
    do_reset();
    w0 = wr_seen;
    send(8'h02); send(8'h00); send(8'h00); send(8'h0A);
    for (int i = 0; i < 20; i++) step(1'b1, 8'hEE, 1'b1);
    check("tp2_no_write_while_full", 64'(wr_seen - w0), 64'd0);
    idle(3, 1'b0);
    check("tp2_writes", 64'(wr_seen - w0), 64'd1);
    check("tp2_data", 64'(last_data), 64'h0200000A);

    // Timeout after 8 idle cycles drops the partial word.
    do_reset();
    w0 = wr_seen;
    send(8'h01); send(8'h00);
    idle(int'(T_CYC), 1'b0);
    check("tp3_timeout", 64'(timeout_count), 64'd1);
    send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    idle(1, 1'b0);
    send(8'h01);
    idle(2, 1'b0);
    check("tp3_writes", 64'(wr_seen - w0), 64'd1);
    check("tp3_data", 64'(last_data), 64'h03000000);

    // Byte on the expiry cycle wins over the timeout.
    do_reset();
    w0 = wr_seen;
    send(8'h01);
    idle(int'(T_CYC) - 1, 1'b0);
    send(8'h00); send(8'h00); send(8'h00);
    idle(2, 1'b0);
    check("tp4_no_timeout", 64'(timeout_count), 64'd0);
    check("tp4_writes", 64'(wr_seen - w0), 64'd1);
    check("tp4_data", 64'(last_data), 64'h01000000);

    // Out-of-range command followed by the highest valid one.
    do_reset();
    w0 = wr_seen;
    send(8'h07); send(8'h00); send(8'h00); send(8'h00);
    idle(2, 1'b0);
    send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    idle(2, 1'b0);
    check("tp5_data", 64'(last_data), 64'h04000000);
`ifdef CMD_FILTER_EN
    check("tp5_writes", 64'(wr_seen - w0), 64'd1);
    check("tp5_rejects", 64'(reject_count), 64'd1);
`else
    check("tp5_writes", 64'(wr_seen - w0), 64'd2);
    check("tp5_rejects", 64'(reject_count), 64'd0);
`endif

    // Reset in the middle of a word, then a fresh word.
    do_reset();
    send(8'h01); send(8'h00); send(8'h10);
    do_reset();
    w0 = wr_seen;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    idle(2, 1'b0);
    check("tp6_writes", 64'(wr_seen - w0), 64'd1);
    check("tp6_data", 64'(last_data), 64'h00000000);
    check("tp6_word_count", 64'(word_count), 64'd1);

    // Randomized traffic with varying byte density and FIFO back-pressure.
    do_reset();
    vprob = 80;
    fprob = 30;
    for (int c = 0; c < 6000; c++) begin
      logic [7:0] b;
      if (c % 64 == 0) begin
        r0    = int'($urandom_range(0, 3));
        vprob = (r0 == 0) ? 95 : (r0 == 1) ? 60 : (r0 == 2) ? 15 : 4;
        fprob = int'($urandom_range(0, 70));
      end
      if (m_part.size() == 0) b = 8'($urandom_range(0, 6));
      else                    b = 8'($urandom);
      if ($urandom_range(0, 2499) == 0) begin
        do_reset();
      end else begin
        step(int'($urandom_range(0, 99)) < vprob, b, int'($urandom_range(0, 99)) < fprob);
      end
    end
    check("rand_word_count_final", 64'(word_count), 64'(m_words));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_cmd_assembler.md
Name: pulse_cmd_assembler

Overview:
Upstream stage of the pulse generator's command FIFO. It accepts a byte stream from the host link (UART/AXI-lite bridge) over a valid/ready handshake and assembles big-endian 32-bit command words: command, coarse high, coarse low, fine. It writes each completed word into the command FIFO that the pulse generator drains. It also provides partial-word timeout recovery and status counters for software.

Parameters:
TIMEOUT_CYCLES, 1000000, idle clk cycles allowed between bytes of a partial word before it is discarded (must be >=1)
CNT_W, 16, width of the timeout/reject status counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
s_byte_data  in  8  host byte
s_byte_valid  in  1  byte valid
s_byte_ready  out  1  byte accepted when valid&ready on rising clk
fifo_full  in  1  command FIFO full
fifo_data  out  32  word to FIFO
fifo_write  out  1  single-cycle FIFO write strobe
word_count  out  32  words written to FIFO since reset, wraps
timeout_count  out  CNT_W  partial words discarded by timeout, saturates
reject_count  out  CNT_W  words rejected by the filter (0 when filter compiled out), saturates
state_out  out  8  current state encoding, for debug

Behaviour:
- Reset (rst low, async): state=S_COLLECT, byte_idx=0, shift reg=0, fifo_data=0, fifo_write=0, all counters=0, timeout timer=0.
- States: S_COLLECT=0, S_PUSH=1; any other encoding returns to reset values on the next edge.
- s_byte_ready = (state==S_COLLECT), combinational from state only.
- S_COLLECT:
  - On handshake, word <= {word[23:0], s_byte_data}; byte_idx++; timer cleared.
  - On the 4th byte (byte_idx==3), byte_idx <= 0 and state <= S_PUSH.
  - First byte received lands in bits [31:24] (command).
- Timeout:
  - In S_COLLECT with byte_idx!=0 and no handshake, timer increments.
  - When timer reaches TIMEOUT_CYCLES-1, byte_idx <= 0, timer <= 0, timeout_count++ (saturating), and the partial word is dropped.
  - Timer is held at 0 whenever byte_idx==0.
  - A handshake in the same cycle as expiry wins: the byte is accepted, the timer is cleared, and there is no timeout.
- S_PUSH (s_byte_ready=0):
  - If fifo_full=0: fifo_data <= word, fifo_write <= 1 for exactly one cycle, word_count++ (wraps at 2^32), state <= S_COLLECT.
  - If fifo_full=1: hold in S_PUSH, fifo_write=0; the word is never lost or duplicated.
- fifo_write is 0 in every cycle it is not explicitly set. fifo_data holds its last value between writes.
- Latency: 4th byte handshake at edge N -> fifo_write high in the cycle after edge N+1 (when not full). Max throughput is 1 word per 5 clk.
- fifo_full is sampled only in S_PUSH. Writes never occur while fifo_full=1.
- Reset mid-word or mid-push discards everything; no FIFO write is issued.

Optional Feature:
- Macro CMD_FILTER_EN.
- When defined: in S_PUSH, a word whose bits [31:24] exceed 4 (the highest defined command code, reset_phase_meas_mode) is not written. reject_count++ (saturating), state <= S_COLLECT, word_count unchanged. This happens regardless of fifo_full.
- When undefined: all words are forwarded and reject_count is tied to 0.

Decomposition:
- Shared package pulse_pkg:
  - command code constants: CMD_RESET_CLOCK=0, CMD_SEND_PULSE=1, CMD_SET_PERIOD=2, CMD_SET_PHASE_MEAS=3, CMD_RESET_PHASE_MEAS=4, CMD_MAX=4
  - field slice constants: command [31:24], coarse [23:8], fine [7:0]
  - assembler state encodings
- Optional sub-module: sat_counter (parameterised width, increment-enable, saturating), instantiated for timeout_count and reject_count.

Test Plan:
- Bytes 01,00,05,03 back-to-back, fifo_full=0 -> one fifo_write pulse with fifo_data=32'h01000503, word_count=1, s_byte_ready low for exactly 1 cycle.
- fifo_full=1 held for 20 cycles after the 4th byte of 02,00,00,0A -> no write and s_byte_ready=0 throughout; full released -> single write of 32'h0200000A.
- TIMEOUT_CYCLES=8: bytes 01,00, then idle 8 cycles, then 03,00,00,00,01 -> timeout_count=1, exactly one write of 32'h03000000. Byte 01 starts a new partial word.
- Byte arriving on the exact expiry cycle (TIMEOUT_CYCLES=8, 2nd byte on cycle 7) -> no timeout; the word completes normally.
- CMD_FILTER_EN defined: bytes 07,00,00,00 then 04,00,00,00 -> reject_count=1, one write of 32'h04000000. Without the macro -> two writes.
- Assert rst after the 3rd byte of 01,00,10 -> all outputs 0. Then 00,00,00,00 -> write of 32'h00000000, word_count=1.
